// File: rtl/bridge_pkg.sv
// Shared types and width helpers for the element-packing bridges.
package bridge_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_t;

  function automatic int min_cnt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int keep_width(input int dout_w);
    return $clog2(dout_w + 1);
  endfunction

  function automatic int cnti_width(input int din_w);
    return $clog2(din_w + 1);
  endfunction

endpackage

// File: rtl/bridge_align.sv
// Drops the low cnt elements of din into the accumulator starting at element offset.
module bridge_align #(
  parameter int DIN_W  = 4,
  parameter int ACC_N  = 12,
  parameter int DATA_W = 8
) (
  input  logic [ACC_N-1:0][DATA_W-1:0]   acc_in,
  input  logic [DIN_W-1:0][DATA_W-1:0]   din,
  input  logic [$clog2(DIN_W+1)-1:0]     cnt,
  input  logic [$clog2(ACC_N+1)-1:0]     offset,
  output logic [ACC_N-1:0][DATA_W-1:0]   acc_out
);

  logic [ACC_N-1:0][DATA_W-1:0] ext;

  // acc_in is zero above offset, so an OR merges without clobbering held elements
  always_comb begin
    ext = '0;
    for (int i = 0; i < DIN_W; i++) begin
      if (i < int'(cnt)) ext[i] = din[i];
    end
    acc_out = acc_in | (ext << (DATA_W * int'(offset)));
  end

endmodule

// File: rtl/bridge_pack.sv
// Packs variable-occupancy input beats densely into fixed-width output words,
// flushing a partial word with an element count at packet end.
module bridge_pack
  import bridge_pkg::*;
#(
  parameter int     DIN_W  = 4,
  parameter int     DOUT_W = 8,
  parameter int     DATA_W = 8,
  parameter order_t ORDER  = ORDER_LSB_FIRST,
  parameter int     CNTI_W = cnti_width(DIN_W),
  parameter int     KEEP_W = keep_width(DOUT_W),
  parameter int     ACC_N  = DOUT_W + DIN_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_i,
  input  logic [DIN_W-1:0][DATA_W-1:0]   din,
  input  logic [CNTI_W-1:0]              cnt_i,
  input  logic                           last_i,
  output logic                           rdy_o,
  output logic                           vld_o,
  output logic [DOUT_W-1:0][DATA_W-1:0]  dout,
  output logic [KEEP_W-1:0]              keep_o,
  output logic                           last_o,
  input  logic                           rdy_i
);

  localparam int CNT_W = $clog2(ACC_N + 1);

  logic [ACC_N-1:0][DATA_W-1:0] acc_q, acc_d, acc_shift;
  logic [CNT_W-1:0]             cnt_q, cnt_d, removed, base;
  logic                         last_pend_q, last_pend_d;
  logic                         accept, fire;
  logic [CNTI_W-1:0]            cnt_clamp, cnt_add;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
    end
  end

  always_comb begin
    vld_o  = (cnt_q >= CNT_W'(DOUT_W)) || last_pend_q;
    keep_o = KEEP_W'(min_cnt(int'(cnt_q), DOUT_W));
    last_o = last_pend_q && (cnt_q <= CNT_W'(DOUT_W));
  end

  assign fire      = vld_o && rdy_i;
  assign rdy_o     = !rst && !last_pend_q && ((cnt_q < CNT_W'(DOUT_W)) || fire);
  assign accept    = vld_i && rdy_o;
  assign cnt_clamp = CNTI_W'(min_cnt(int'(cnt_i), DIN_W));
  assign cnt_add   = accept ? cnt_clamp : '0;

  // The outgoing word leaves first, so the new beat lands right after what survives
  assign removed   = fire ? CNT_W'(keep_o) : '0;
  assign base      = cnt_q - removed;
  assign acc_shift = acc_q >> (DATA_W * int'(removed));
  assign cnt_d     = base + CNT_W'(cnt_add);

  bridge_align #(
    .DIN_W (DIN_W),
    .ACC_N (ACC_N),
    .DATA_W(DATA_W)
  ) u_align (
    .acc_in (acc_shift),
    .din    (din),
    .cnt    (cnt_add),
    .offset (base),
    .acc_out(acc_d)
  );

  always_comb begin
    last_pend_d = last_pend_q;
    if (fire && last_o)   last_pend_d = 1'b0;
    if (accept && last_i) last_pend_d = 1'b1;
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < DOUT_W; k++) begin
      if (k < int'(keep_o)) begin
        if (ORDER == ORDER_MSB_FIRST) dout[DOUT_W-1-k] = acc_q[k];
        else                          dout[k]          = acc_q[k];
      end
    end
  end

endmodule

// File: tb/tb_bridge_pack.sv
// Randomised scoreboard bench for bridge_pack, running both element orders side by side.
`timescale 1ns/1ps
module tb_bridge_pack;
  import bridge_pkg::*;

  localparam int DIN_W  = 3;
  localparam int DOUT_W = 8;
  localparam int DATA_W = 8;
  localparam int CNTI_W = cnti_width(DIN_W);
  localparam int KEEP_W = keep_width(DOUT_W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld_i = 1'b0;
  logic last_i = 1'b0;
  logic rdy_i = 1'b1;
  logic [DIN_W-1:0][DATA_W-1:0] din = '0;
  logic [CNTI_W-1:0] cnt_i = '0;

  logic rdy_o0, vld_o0, last_o0, rdy_o1, vld_o1, last_o1;
  logic [DOUT_W-1:0][DATA_W-1:0] dout0, dout1;
  logic [KEEP_W-1:0] keep_o0, keep_o1;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;

  // Elements accepted but not yet emitted, and remaining counts of ended packets
  logic [DATA_W-1:0] exp_q[$];
  int ends[$];

  bit m_pend, m_vld, m_rdy, m_last, stall_prev;
  int m_keep;
  logic [63:0] w0, w1, hold_d0, hold_d1;
  logic [KEEP_W-1:0] hold_k;
  logic hold_l;

  bridge_pack #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .DATA_W(DATA_W), .ORDER(ORDER_LSB_FIRST)
  ) dut0 (
    .clk(clk), .rst(rst), .vld_i(vld_i), .din(din), .cnt_i(cnt_i), .last_i(last_i),
    .rdy_o(rdy_o0), .vld_o(vld_o0), .dout(dout0), .keep_o(keep_o0), .last_o(last_o0),
    .rdy_i(rdy_i)
  );

  bridge_pack #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .DATA_W(DATA_W), .ORDER(ORDER_MSB_FIRST)
  ) dut1 (
    .clk(clk), .rst(rst), .vld_i(vld_i), .din(din), .cnt_i(cnt_i), .last_i(last_i),
    .rdy_o(rdy_o1), .vld_o(vld_o1), .dout(dout1), .keep_o(keep_o1), .last_o(last_o1),
    .rdy_i(rdy_i)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ended_total();
    int s = 0;
    foreach (ends[i]) s += ends[i];
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_i = 1'b1;
      1:       rdy_i = ($urandom_range(0, 9) < 7);
      default: rdy_i = 1'b0;
    endcase
  end

  // Monitor: compares what the DUTs present against the element-level model
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      m_pend = (ends.size() > 0);
      m_vld  = m_pend || (exp_q.size() >= DOUT_W);
      m_rdy  = !m_pend && ((exp_q.size() < DOUT_W) || (m_vld && rdy_i));
      check_output("vld_o", 64'(vld_o0), 64'(m_vld));
      check_output("vld_o_msb", 64'(vld_o1), 64'(m_vld));
      check_output("rdy_o", 64'(rdy_o0), 64'(m_rdy));
      check_output("rdy_o_msb", 64'(rdy_o1), 64'(m_rdy));
      if (stall_prev) begin
        check_output("stall_dout", dout0, hold_d0);
        check_output("stall_dout_msb", dout1, hold_d1);
        check_output("stall_keep", 64'(keep_o0), 64'(hold_k));
        check_output("stall_last", 64'(last_o0), 64'(hold_l));
      end
      if (m_vld) begin
        m_keep = m_pend ? min_cnt(ends[0], DOUT_W) : DOUT_W;
        m_last = m_pend && (ends[0] <= DOUT_W);
        w0 = '0;
        w1 = '0;
        for (int k = 0; k < m_keep && k < exp_q.size(); k++) begin
          w0[k*DATA_W +: DATA_W] = exp_q[k];
          w1[(DOUT_W-1-k)*DATA_W +: DATA_W] = exp_q[k];
        end
        check_output("keep_o", 64'(keep_o0), 64'(m_keep));
        check_output("keep_o_msb", 64'(keep_o1), 64'(m_keep));
        check_output("last_o", 64'(last_o0), 64'(m_last));
        check_output("last_o_msb", 64'(last_o1), 64'(m_last));
        check_output("dout", dout0, w0);
        check_output("dout_msb", dout1, w1);
        if (rdy_i) begin
          for (int k = 0; k < m_keep; k++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
          if (m_pend) begin
            ends[0] = ends[0] - m_keep;
            if (m_last) void'(ends.pop_front());
          end
        end
      end
      stall_prev = vld_o0 && !rdy_i;
      hold_d0 = dout0;
      hold_d1 = dout1;
      hold_k  = keep_o0;
      hold_l  = last_o0;
    end
  end

  // Entered and left at posedge+1; holds the beat until accepted
  task automatic apply_stimulus(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input int cnt, input bit last);
    int waited = 0;
    bit done = 1'b0;
    vld_i  = 1'b1;
    din[0] = e0;
    din[1] = e1;
    din[2] = e2;
    cnt_i  = CNTI_W'(cnt);
    last_i = last;
    while (!done) begin
      @(negedge clk);
      if (rdy_o0) begin
        #1;
        for (int i = 0; i < min_cnt(cnt, DIN_W); i++) exp_q.push_back(din[i]);
        if (last) ends.push_back(exp_q.size() - ended_total());
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL accept_timeout: rdy_o stuck at %b, expected 1 within 200 cycles", rdy_o0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    vld_i  = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    @(negedge clk);
    check_output("reset_vld", 64'(vld_o0), 64'd0);
    check_output("reset_rdy", 64'(rdy_o0), 64'd0);
    check_output("reset_keep", 64'(keep_o0), 64'd0);
    check_output("reset_last", 64'(last_o0), 64'd0);
    check_output("reset_dout", dout0, 64'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] full beats, element 9 carried over then flushed");
    apply_stimulus(8'd1, 8'd2, 8'd3, 3, 1'b0);
    apply_stimulus(8'd4, 8'd5, 8'd6, 3, 1'b0);
    apply_stimulus(8'd7, 8'd8, 8'd9, 3, 1'b0);
    idle(2);
    apply_stimulus(8'd0, 8'd0, 8'd0, 0, 1'b1);
    idle(3);

    $display("[TB] last on third beat");
    apply_stimulus(8'd1, 8'd2, 8'd3, 3, 1'b0);
    apply_stimulus(8'd4, 8'd5, 8'd6, 3, 1'b0);
    apply_stimulus(8'd7, 8'd8, 8'd9, 3, 1'b1);
    idle(3);

    $display("[TB] variable counts 2,0,3,1,2");
    apply_stimulus(8'd1, 8'd2, 8'hEE, 2, 1'b0);
    apply_stimulus(8'hEE, 8'hEE, 8'hEE, 0, 1'b0);
    apply_stimulus(8'd3, 8'd4, 8'd5, 3, 1'b0);
    apply_stimulus(8'd6, 8'hEE, 8'hEE, 1, 1'b0);
    apply_stimulus(8'd7, 8'd8, 8'hEE, 2, 1'b1);
    idle(3);

    $display("[TB] backpressure with nine held elements");
    rdy_mode = 2;
    idle(1);
    apply_stimulus(8'd21, 8'd22, 8'd23, 3, 1'b0);
    apply_stimulus(8'd24, 8'd25, 8'd26, 3, 1'b0);
    apply_stimulus(8'd27, 8'd28, 8'd29, 3, 1'b0);
    idle(5);
    rdy_mode = 0;
    apply_stimulus(8'd30, 8'd31, 8'd32, 3, 1'b1);
    idle(4);

    $display("[TB] reset mid-packet");
    apply_stimulus(8'd40, 8'd41, 8'd42, 3, 1'b0);
    apply_stimulus(8'd43, 8'd44, 8'hEE, 2, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    ends.delete();
    repeat (2) begin
      @(negedge clk);
      check_output("midreset_vld", 64'(vld_o0), 64'd0);
      check_output("midreset_rdy", 64'(rdy_o0), 64'd0);
      check_output("midreset_keep", 64'(keep_o0), 64'd0);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(8'd10, 8'd11, 8'd12, 3, 1'b0);
    apply_stimulus(8'd13, 8'd14, 8'd15, 3, 1'b0);
    apply_stimulus(8'd16, 8'd17, 8'hEE, 2, 1'b1);
    idle(3);
    apply_stimulus(8'd0, 8'd0, 8'd0, 0, 1'b1);
    idle(3);

    $display("[TB] random traffic");
    rdy_mode = 1;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      apply_stimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0));
    end

    rdy_mode = 0;
    apply_stimulus(8'd0, 8'd0, 8'd0, 0, 1'b1);
    waited = 0;
    while ((exp_q.size() > 0 || ends.size() > 0) && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check_output("drain_elements_left", 64'(exp_q.size()), 64'd0);
    check_output("drain_packets_left", 64'(ends.size()), 64'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bridge_pack.md
Name: bridge_pack

Overview:
- Parametrised element-packing width bridge. Successor to the fixed-ratio combine bridge.
- Accepts input beats of up to DIN_W elements with a per-beat valid count, and packs them densely into DOUT_W-element output words.
- DOUT_W need not be a multiple of DIN_W. Elements that do not fit carry over into the next word.
- Packet end (last) flushes a partial word with an element count (keep_o). Output element order is selectable.
- Sits between variable-occupancy producers (zero-skip compaction stages) and fixed-width consumers.

Parameters:
- DIN_W, 4, max elements per input beat.
- DOUT_W, 8, elements per output word. Constraint: DIN_W <= DOUT_W.
- DATA_W, 8, bits per element.
- ORDER, 0, 0 = oldest element at dout[0]; 1 = oldest element at dout[DOUT_W-1].
- CNTI_W, $clog2(DIN_W+1), width of cnt_i.
- KEEP_W, $clog2(DOUT_W+1), width of keep_o.
- ACC_N, DOUT_W+DIN_W, accumulator depth in elements.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- vld_i, input, 1, input beat valid.
- din, input, [DIN_W-1:0][DATA_W-1:0], elements, low-aligned; din[0] is oldest.
- cnt_i, input, CNTI_W, number of valid elements in din (0..DIN_W).
- last_i, input, 1, beat ends the packet.
- rdy_o, output, 1, bridge accepts a beat.
- vld_o, output, 1, output word valid.
- dout, output, [DOUT_W-1:0][DATA_W-1:0], packed word.
- keep_o, output, KEEP_W, valid element count in dout.
- last_o, output, 1, final word of the packet.
- rdy_i, input, 1, downstream ready.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset state:
  - acc_q = 0, cnt_q = 0, last_pend_q = 0.
  - vld_o = 0, last_o = 0, keep_o = 0, dout = 0.
  - rdy_o is forced 0 while rst is high.
- Reset mid-packet discards all buffered elements. No partial word is emitted.
- Accept and fire conditions:
  - accept = vld_i && rdy_o.
  - fire = vld_o && rdy_i.
- rdy_o = !rst && !last_pend_q && (cnt_q < DOUT_W || fire). The rdy_i -> rdy_o combinational path is permitted.
- cnt_i > DIN_W is clamped to DIN_W. din elements at index >= cnt_i are ignored.
- On accept, elements are appended after the cnt_q oldest held elements.
  - cnt_i = 0 is legal; the beat adds nothing.
  - last_i on an accepted beat sets last_pend_q.
- vld_o = (cnt_q >= DOUT_W) || last_pend_q.
- keep_o = min(cnt_q, DOUT_W).
- last_o = last_pend_q && (cnt_q <= DOUT_W).
- On fire:
  - The oldest keep_o elements are removed.
  - cnt_q reduces by keep_o.
  - If last_o is set, last_pend_q clears.
- Simultaneous fire and accept: remove first, then append. cnt_d = cnt_q - keep_o + cnt_i.
- Occupancy bound: cnt_q <= DOUT_W+DIN_W-1 always. ACC_N is never exceeded.
- Last with overflow: if last_pend_q and cnt_q > DOUT_W, emit a full word with last_o = 0, then the remainder with last_o = 1.
- Zero-length terminator: last with cnt_q = 0 emits one word with keep_o = 0, last_o = 1, dout = 0.
- Output placement:
  - dout, vld_o, keep_o and last_o are derived from registered state only.
  - Latency from accept to visibility on dout is 1 cycle minimum.
  - ORDER = 0: k-th oldest element at dout[k].
  - ORDER = 1: k-th oldest element at dout[DOUT_W-1-k].
  - Unused positions are driven 0.
- Stability: while vld_o && !rdy_i, dout, keep_o and last_o hold stable.
- Throughput: sustained 1 output word per cycle when the input supplies >= DOUT_W elements per cycle on average. No bubbles are inserted by the bridge.
- State is encoded by cnt_q and last_pend_q:
  - EMPTY: cnt_q = 0.
  - FILL: 0 < cnt_q < DOUT_W.
  - READY: cnt_q >= DOUT_W.
  - FLUSH: last_pend_q = 1.

Decomposition:
- Package bridge_pkg holds:
  - typedef order_t {ORDER_LSB_FIRST, ORDER_MSB_FIRST}.
  - Function min_cnt.
  - KEEP_W / CNTI_W helper functions shared with other bridges.
- One sub-module, bridge_align: combinational element shifter that places din at offset (cnt_q - removed) into the accumulator. Parameters DIN_W, ACC_N, DATA_W.

Test Plan (DIN_W=3, DOUT_W=8, DATA_W=8 unless noted):
- Three full beats with values 1..9, last_i = 0, rdy_i = 1 -> one cycle after the third accept: vld_o = 1, dout[0..7] = 1..8, keep_o = 8, last_o = 0. Element 9 is retained, cnt_q = 1.
- Same stimulus with last_i on the third beat -> word 1..8 (last_o = 0), then word {9, 0 x7} with keep_o = 1, last_o = 1. Afterwards cnt_q = 0 and rdy_o = 1.
- Variable counts 2,0,3,1,2 (values 1..8) with the last flag on the final beat -> single word 1..8, keep_o = 8, last_o = 1.
- Backpressure: cnt_q = 9, rdy_i low for 5 cycles -> rdy_o = 0, and vld_o / dout / keep_o are stable all 5 cycles. On release, no element is lost or duplicated (scoreboard check).
- ORDER = 1, first scenario -> dout[7] = 1 ... dout[0] = 8. For a last remainder of 1 element: dout[7] = 9, keep_o = 1.
- Reset mid-packet: cnt_q = 5, then assert rst for 2 cycles asynchronously -> vld_o = 0 and rdy_o = 0 during reset. The next packet (values 10..17) emerges alone with no stale data. A zero-length last beat on the empty bridge -> keep_o = 0, last_o = 1.
